// File: rtl/score_bcd_decoder.sv
// Iterative double-dabble binary-to-BCD decoder with seven-segment outputs; result W cycles after start.
// No backpressure: start is only honoured in IDLE and is dropped (not queued) while busy.
module score_bcd_decoder #(
  parameter int W        = 13,
  parameter bit BLANK_LZ = 1'b0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] value,
  output logic         busy,
  output logic         done,
  output logic [15:0]  bcd,
  output logic [6:0]   hex0,
  output logic [6:0]   hex1,
  output logic [6:0]   hex2,
  output logic [6:0]   hex3
);

  typedef enum logic {IDLE, SHIFT} state_t;

  localparam int            CW       = 4;
  localparam logic [CW-1:0] LAST     = CW'(W - 1);
  localparam logic [6:0]    SEG_ZERO = 7'h40;
  localparam logic [6:0]    SEG_OFF  = 7'h7F;
  localparam logic [6:0]    HI_RST   = BLANK_LZ ? SEG_OFF : SEG_ZERO;

  state_t        state;
  logic [W-1:0]  sreg;
  logic [15:0]   scratch;
  logic [CW-1:0] cnt;

  logic [15:0] adj;
  logic [15:0] shifted;
  logic [6:0]  h0_next, h1_next, h2_next, h3_next;
  logic        z3, z2, z1;

  function automatic logic [6:0] seg7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = SEG_OFF;
    endcase
    return s;
  endfunction

  // Add-3 correction on every nibble, then shift the next binary bit in.
  always_comb begin
    adj = scratch;
    for (int i = 0; i < 4; i++) begin
      if (scratch[i*4 +: 4] >= 4'd5)
        adj[i*4 +: 4] = scratch[i*4 +: 4] + 4'd3;
    end
    shifted = {adj[14:0], sreg[W-1]};
  end

  // Segments are derived from the final scratch so they land in the same cycle as bcd.
  always_comb begin
    z3      = (shifted[15:12] == 4'd0);
    z2      = z3 && (shifted[11:8] == 4'd0);
    z1      = z2 && (shifted[7:4] == 4'd0);
    h0_next = seg7(shifted[3:0]);
    h1_next = (BLANK_LZ && z1) ? SEG_OFF : seg7(shifted[7:4]);
    h2_next = (BLANK_LZ && z2) ? SEG_OFF : seg7(shifted[11:8]);
    h3_next = (BLANK_LZ && z3) ? SEG_OFF : seg7(shifted[15:12]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sreg    <= '0;
      scratch <= '0;
      cnt     <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
      hex0    <= SEG_ZERO;
      hex1    <= HI_RST;
      hex2    <= HI_RST;
      hex3    <= HI_RST;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sreg    <= value;
            scratch <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= shifted;
          sreg    <= sreg << 1;
          cnt     <= cnt + 1'b1;
          if (cnt == LAST) begin
            bcd   <= shifted;
            hex0  <= h0_next;
            hex1  <= h1_next;
            hex2  <= h2_next;
            hex3  <= h3_next;
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_score_bcd_decoder.sv
// Randomised scoreboard bench for score_bcd_decoder, plain and leading-zero-blanked variants side by side.
module tb_score_bcd_decoder;

  localparam int W = 13;

  typedef struct {
    logic [15:0] bcd;
    logic [6:0]  h0, h1, h2, h3;
    int          due;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] value;

  logic        busy0, done0, busy1, done1;
  logic [15:0] bcd0, bcd1;
  logic [6:0]  a0, a1, a2, a3, b0, b1, b2, b3;

  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  exp_t q0[$];
  exp_t q1[$];

  logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                               7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  score_bcd_decoder #(.W(W), .BLANK_LZ(1'b0)) dut (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy0), .done(done0), .bcd(bcd0),
    .hex0(a0), .hex1(a1), .hex2(a2), .hex3(a3)
  );

  score_bcd_decoder #(.W(W), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .rst(rst), .start(start), .value(value),
    .busy(busy1), .done(done1), .bcd(bcd1),
    .hex0(b0), .hex1(b1), .hex2(b2), .hex3(b3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference: decimal digits by division, blanking by magnitude of the number.
  function automatic exp_t model(input int v, input bit blank, input int due);
    exp_t e;
    int d3, d2, d1, d0;
    d3 = v / 1000;
    d2 = (v / 100) % 10;
    d1 = (v / 10) % 10;
    d0 = v % 10;
    e.bcd = 16'(d3 * 4096 + d2 * 256 + d1 * 16 + d0);
    e.h0  = seg_tab[d0];
    e.h1  = (blank && v < 10)   ? 7'h7F : seg_tab[d1];
    e.h2  = (blank && v < 100)  ? 7'h7F : seg_tab[d2];
    e.h3  = (blank && v < 1000) ? 7'h7F : seg_tab[d3];
    e.due = due;
    return e;
  endfunction

  task automatic push(input int v);
    q0.push_back(model(v, 1'b0, cyc + 1 + W));
    q1.push_back(model(v, 1'b1, cyc + 1 + W));
  endtask

  // Monitor: every done pulse must match the oldest outstanding request, on the predicted cycle.
  always @(negedge clk) begin
    if (!rst) begin
      if (busy0 && done0) chk("busy_done_overlap", 1, 0);
      if (busy1 && done1) chk("busy_done_overlap_b", 1, 0);
      if (done0) begin
        if (q0.size() == 0) chk("unexpected_done", 1, 0);
        else begin
          exp_t e;
          e = q0.pop_front();
          chk("done_cycle", cyc, e.due);
          chk("bcd", bcd0, e.bcd);
          chk("hex0", a0, e.h0);
          chk("hex1", a1, e.h1);
          chk("hex2", a2, e.h2);
          chk("hex3", a3, e.h3);
        end
      end
      if (done1) begin
        if (q1.size() == 0) chk("unexpected_done_b", 1, 0);
        else begin
          exp_t e;
          e = q1.pop_front();
          chk("done_cycle_b", cyc, e.due);
          chk("bcd_b", bcd1, e.bcd);
          chk("hex0_b", b0, e.h0);
          chk("hex1_b", b1, e.h1);
          chk("hex2_b", b2, e.h2);
          chk("hex3_b", b3, e.h3);
        end
      end
    end
  end

  // Idle cycles with start low and value scrambled to show it is not re-sampled.
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      start = 1'b0;
      value = W'($urandom);
    end
  endtask

  task automatic conv(input int v, input int gap);
    @(negedge clk);
    start = 1'b1;
    value = W'(v);
    push(v);
    @(negedge clk);
    start = 1'b0;
    chk("busy_rise", busy0, 1);
    chk("busy_rise_b", busy1, 1);
    idle(W - 1 + gap);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bcd"}, bcd0, 16'h0000);
    chk({tag, "_busy"}, busy0, 0);
    chk({tag, "_done"}, done0, 0);
    chk({tag, "_hex"}, {a3, a2, a1, a0}, {7'h40, 7'h40, 7'h40, 7'h40});
    chk({tag, "_bcd_b"}, bcd1, 16'h0000);
    chk({tag, "_busy_b"}, busy1, 0);
    chk({tag, "_hex_b"}, {b3, b2, b1, b0}, {7'h7F, 7'h7F, 7'h7F, 7'h40});
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    value = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_outputs("reset");

    conv(8191, 0);
    conv(7, 1);
    conv(0, 2);

    // Second start mid-conversion must be dropped.
    @(negedge clk);
    start = 1'b1;
    value = W'(1234);
    push(1234);
    @(negedge clk);
    start = 1'b0;
    idle(3);
    @(negedge clk);
    start = 1'b1;
    value = '0;
    @(negedge clk);
    start = 1'b0;
    idle(7);

    // Start held high: one result per W+1 cycles.
    @(negedge clk);
    start = 1'b1;
    value = '0;
    push(0);
    repeat (W + 1) @(negedge clk);
    value = W'(999);
    push(999);
    repeat (W + 1) @(negedge clk);
    value = W'(8191);
    push(8191);
    @(negedge clk);
    start = 1'b0;
    idle(W + 2);

    // Reset mid-conversion aborts with no done.
    @(negedge clk);
    start = 1'b1;
    value = W'(4095);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_outputs("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    conv(50, 0);

    conv(9, 0);
    conv(10, 0);
    conv(99, 0);
    conv(100, 0);
    conv(1000, 0);
    for (int i = 0; i < 30; i++)
      conv(int'($urandom_range(0, 8191)), int'($urandom_range(0, 3)));

    idle(20);
    chk("pending_results", q0.size(), 0);
    chk("pending_results_b", q1.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
